// File: rtl/booth_mul_arbiter.sv
// Purpose : two-requester arbiter/sequencer in front of one shared serial-load Booth multiplier.
// Latency : ack one cycle after req is seen in IDLE; vld at cycle 5+k for m_done at cycle 3+k.
// Backpr. : a losing or late requester simply holds req; it is re-arbitrated at the next IDLE.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   reqN_i, aN_i, bN_i         requester N request and two's complement operands
//   ackN_o                     one-cycle pulse, operands of requester N latched
//   vldN_o                     one-cycle pulse, prod_o/err_o valid for requester N
//   prod_o, err_o              shared result bus and timeout flag
//   m_start_o, m_data_in_o     multiplier start and serial operand bus
//   m_data_out_i, m_done_i     multiplier result bus (low half, then high half) and done
//
// Build option: define BOOTH_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; without it requester 0 always wins a tie.
module booth_mul_arbiter #(
   parameter int WIDTH   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req0_i,
   input  logic [WIDTH-1:0]   a0_i,
   input  logic [WIDTH-1:0]   b0_i,
   output logic               ack0_o,
   output logic               vld0_o,
   input  logic               req1_i,
   input  logic [WIDTH-1:0]   a1_i,
   input  logic [WIDTH-1:0]   b1_i,
   output logic               ack1_o,
   output logic               vld1_o,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               err_o,
   output logic               m_start_o,
   output logic [WIDTH-1:0]   m_data_in_o,
   input  logic [WIDTH-1:0]   m_data_out_i,
   input  logic               m_done_i
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LOAD_A,
      S_LOAD_B,
      S_WAIT,
      S_CAP_HI,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic                 win_q, win_d;      // 0 = requester 0, 1 = requester 1
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     lo_q, lo_d;        // low product half, parked until CAP_HI
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 err_q, err_d;
   logic                 pick1;

`ifdef BOOTH_ARB_ROUND_ROBIN_EN
   logic                 last_q, last_d;

   // On a tie, grant whoever did not win last time.
   assign pick1 = req1_i && (!req0_i || !last_q);
`else
   // Fixed priority: requester 1 only wins when requester 0 is idle.
   assign pick1 = req1_i && !req0_i;
`endif

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      lo_d        = lo_q;
      prod_d      = prod_q;
      err_d       = err_q;
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      ack0_o      = 1'b0;
      ack1_o      = 1'b0;
      vld0_o      = 1'b0;
      vld1_o      = 1'b0;
      err_o       = 1'b0;
      m_start_o   = 1'b0;
      m_data_in_o = '0;

      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               win_d   = pick1;
               state_d = S_START;
            end
         end

         S_START: begin
            m_start_o = 1'b1;
            a_d       = win_q ? a1_i : a0_i;
            b_d       = win_q ? b1_i : b0_i;
            ack0_o    = !win_q;
            ack1_o    = win_q;
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
            last_d    = win_q;
`endif
            state_d   = S_LOAD_A;
         end

         S_LOAD_A: begin
            m_data_in_o = a_q;
            state_d     = S_LOAD_B;
         end

         S_LOAD_B: begin
            m_data_in_o = b_q;
            cnt_d       = '0;
            err_d       = 1'b0;
            state_d     = S_WAIT;
         end

         S_WAIT: begin
            if (m_done_i) begin
               lo_d    = m_data_out_i;
               state_d = S_CAP_HI;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Multiplier never answered: report a zero product flagged as error.
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_CAP_HI: begin
            prod_d  = {m_data_out_i, lo_q};
            state_d = S_RESP;
         end

         S_RESP: begin
            vld0_o  = !win_q;
            vld1_o  = win_q;
            err_o   = err_q;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign prod_o = prod_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         win_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         lo_q    <= '0;
         prod_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         prod_q  <= prod_d;
         err_q   <= err_d;
      end
   end

`ifdef BOOTH_ARB_ROUND_ROBIN_EN
   // Starts at 1 so that requester 0 wins the first tie after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [4:0] a0, b0, a1, b1;
   logic       ack0, ack1, vld0, vld1;
   logic [9:0] prod;
   logic       err;
   logic       m_start;
   logic [4:0] m_din;
   logic [4:0] m_dout;
   logic       m_done;

   int n_vec  = 0;
   int n_miss = 0;
   int hot_viol = 0;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.WIDTH(5), .TIMEOUT(64)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_i       (req0),
      .a0_i         (a0),
      .b0_i         (b0),
      .ack0_o       (ack0),
      .vld0_o       (vld0),
      .req1_i       (req1),
      .a1_i         (a1),
      .b1_i         (b1),
      .ack1_o       (ack1),
      .vld1_o       (vld1),
      .prod_o       (prod),
      .err_o        (err),
      .m_start_o    (m_start),
      .m_data_in_o  (m_din),
      .m_data_out_i (m_dout),
      .m_done_i     (m_done)
   );

   // Multiplier stand-in: captures A then B after start, raises done mdl_k
   // cycles after B (k counted as in "done at cycle 3+k"), low half first.
   int                 mdl_k = 12;   // 0 = never answer
   logic               mdl_extra = 1'b0;
   int                 ph = 0;
   int                 nn = 0;
   logic signed [4:0]  ma = '0, mb = '0;
   logic signed [9:0]  mprod;
   assign mprod = ma * mb;

   always @(posedge clk) begin
      if (rst) begin
         ph <= 0; m_done <= 1'b0; m_dout <= '0;
      end else if (m_start) begin
         ph <= 1; m_done <= 1'b0; m_dout <= '0;
      end else begin
         case (ph)
            1: begin ma <= m_din; ph <= 2; end
            2: begin mb <= m_din; nn <= 2; ph <= 3; end
            3: begin
               if (mdl_k != 0 && nn == mdl_k) begin
                  m_done <= 1'b1; m_dout <= mprod[4:0]; ph <= 4;
               end
               nn <= nn + 1;
            end
            4: begin m_done <= mdl_extra; m_dout <= mprod[9:5]; ph <= 5; end
            5: begin m_done <= 1'b0; m_dout <= '0; ph <= 0; end
            default: ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if ($countones({ack0, ack1, vld0, vld1}) > 1) hot_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_vld(output int m);
      m = 0;
      do begin
         tick();
         m++;
      end while (!(vld0 || vld1) && m < 200);
   endtask

   // One complete operation from an idle arbiter; ack expected 1 cycle after
   // the request, vld at 5+k (or after 64 WAIT cycles when the model is mute).
   task automatic run_op(input int who, input logic [4:0] a, input logic [4:0] b,
                         input int k, input logic [9:0] ep, input logic ee);
      int n;
      int m;
      logic [1:0] oh;
      oh = (who == 1) ? 2'b10 : 2'b01;
      mdl_k = k;
      if (who == 1) begin req1 = 1'b1; a1 = a; b1 = b; end
      else          begin req0 = 1'b1; a0 = a; b0 = b; end
      n = 0;
      do begin
         tick();
         n++;
      end while (!(ack0 || ack1) && n < 20);
      chk("op_ack_who", {ack1, ack0}, oh);
      chk("op_ack_lat", n, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_vld(m);
      chk("op_vld_who", {vld1, vld0}, oh);
      chk("op_vld_lat", m, (k == 0) ? 67 : 4 + k);
      chk("op_prod", prod, ep);
      chk("op_err", err, ee);
      tick();
      chk("op_vld_pulse", {vld1, vld0}, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int m;
      int n;
      int exp_w;
      int seen;

      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) tick();
      chk("reset_outs", {ack0, ack1, vld0, vld1, err, m_start, m_din, prod}, 0);

      // Single op, cycle by cycle: 13 * 10 = 130
      rst = 1'b0;
      mdl_k = 12;
      req0 = 1'b1; a0 = 5'b01101; b0 = 5'b01010;
      tick();
      chk("c1_ack0", ack0, 1);
      chk("c1_ack1", ack1, 0);
      chk("c1_start", m_start, 1);
      req0 = 1'b0;
      tick();
      chk("c2_start", m_start, 0);
      chk("c2_din_a", m_din, 5'b01101);
      tick();
      chk("c3_din_b", m_din, 5'b01010);
      tick();
      chk("c4_din_wait", m_din, 0);
      wait_vld(m);
      chk("c17_lat", m, 13);
      chk("c17_vld0", {vld1, vld0}, 2'b01);
      chk("c17_prod", prod, 10'd130);
      chk("c17_err", err, 0);
      tick();

      // Signed operands on requester 1
      run_op(1, 5'b11101, 5'b01010, 2, 10'h3E2, 1'b0);   // -3 * 10 = -30
      run_op(1, 5'b11101, 5'b11010, 5, 10'd18, 1'b0);    // -3 * -6 = 18

      // Contention: both held high for three back-to-back operations
      mdl_k = 3;
      a0 = 5'd2; b0 = 5'd3;                 // 6
      a1 = 5'b11111; b1 = 5'b00100;         // -1 * 4 = -4
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
         exp_w = i % 2;
`else
         exp_w = 0;
`endif
         n = 0;
         do begin
            tick();
            n++;
         end while (!(ack0 || ack1) && n < 20);
         chk("cont_ack", {ack1, ack0}, (exp_w == 1) ? 2'b10 : 2'b01);
         if (i == 2) begin req0 = 1'b0; req1 = 1'b0; end
         wait_vld(m);
         chk("cont_vld", {vld1, vld0}, (exp_w == 1) ? 2'b10 : 2'b01);
         chk("cont_prod", prod, (exp_w == 1) ? 10'h3FC : 10'd6);
      end
      tick();

      // Zero operand, with a stray done held into CAP_HI
      mdl_extra = 1'b1;
      run_op(0, 5'b00000, 5'b01010, 3, 10'd0, 1'b0);
      mdl_extra = 1'b0;

      // Timeout, then a normal op afterwards
      run_op(0, 5'd3, 5'd3, 0, 10'd0, 1'b1);
      run_op(1, 5'd7, 5'b11110, 4, 10'h3F2, 1'b0);       // 7 * -2 = -14

      // Reset while waiting on the multiplier
      mdl_k = 0;
      req0 = 1'b1; a0 = 5'd5; b0 = 5'd5;
      tick();
      chk("rmid_ack0", ack0, 1);
      req0 = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      chk("rmid_outs", {ack0, ack1, vld0, vld1, err, m_start, m_din, prod}, 0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (vld0 || vld1) seen++;
      end
      chk("rmid_no_vld", seen, 0);
      run_op(1, 5'd3, 5'd5, 4, 10'd15, 1'b0);

      chk("one_hot_handshakes", hot_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 5-bit serial-load Booth multiplier.
- Accepts a full operand pair from each requester and owns the multiplier's start/data_in/data_out/done protocol.
- Reassembles the 10-bit signed product and returns it to the granted requester.
- Sits between client datapaths and one multiplier instance; the multiplier is never driven by clients directly.

Parameters:
- WIDTH, 5, operand width and width of the multiplier data bus; product is 2*WIDTH.
- TIMEOUT, 64, max cycles spent in WAIT before aborting the operation.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 request; a0/b0 held stable while high and ack0 low
- a0  in  WIDTH  requester 0 multiplicand, two's complement
- b0  in  WIDTH  requester 0 multiplier, two's complement
- ack0  out  1  one-cycle pulse: requester 0 operands latched
- vld0  out  1  one-cycle pulse: prod/err valid for requester 0
- req1, a1, b1, ack1, vld1: same as above for requester 1
- prod  out  2*WIDTH  shared result bus, valid only with vld0/vld1
- err  out  1  pulses with vldN when the operation timed out
- m_start  out  1  multiplier start
- m_data_in  out  WIDTH  multiplier serial operand bus
- m_data_out  in  WIDTH  multiplier result bus
- m_done  in  1  multiplier done

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, last-grant register = 1 (requester 0 wins first tie). Reset in any state aborts immediately: no ack/vld is issued for the in-flight operation, and m_start is 0 the cycle after reset is sampled.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, CAP_HI, RESP.
- IDLE:
  - Evaluate req0/req1 and pick a winner by arbitration; no request stays in IDLE.
  - Winner id is registered; go to START.
- START:
  - m_start=1 for exactly this cycle.
  - Latch winner's a/b into internal registers; ackN=1 this cycle.
  - Go to LOAD_A.
- LOAD_A: m_data_in = latched A; go to LOAD_B.
- LOAD_B: m_data_in = latched B; go to WAIT; clear timeout counter.
- m_data_in is 0 in every other state.
- WAIT:
  - m_done=1: register m_data_out as the low half prod[WIDTH-1:0]; go to CAP_HI.
  - Otherwise the counter increments. Counter reaching TIMEOUT-1 with m_done still 0: prod=0, err flag set, go to RESP.
- CAP_HI: register m_data_out as the high half prod[2*WIDTH-1:WIDTH]; go to RESP.
- RESP:
  - vldN=1 for the registered winner; err=1 only on timeout.
  - prod held from CAP_HI until the next RESP.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle 0; ack at 1; m_start at 1; A at 2; B at 3. With m_done at cycle 3+k (k>=1), vld occurs at cycle 5+k.
- Requester contract:
  - After ack, the requester may drop req or change operands.
  - A req still high in the IDLE following RESP is a new request.
  - req dropped before ack is a withdrawn request; only requests visible in IDLE are arbitrated.
- Simultaneous req0 and req1 in IDLE: winner per arbitration rule; the loser waits, with no ack, until the next IDLE.
- m_done outside WAIT is ignored.
- Arithmetic: no sign handling in this block; the product is two's complement exactly as the multiplier presents it.
- At most one of ack0/ack1/vld0/vld1 is high in any cycle.

Optional Feature:
- Macro BOOTH_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the requester not equal to last-grant. Last-grant updates in START.
- Undefined: fixed priority, requester 0 always wins ties. Last-grant register is not implemented.

Test Plan:
- Single op: rst 2 cycles, req0 with a0=5'b01101, b0=5'b01010, model done after 12 cycles -> ack0 at cycle 1; m_start 1 cycle; m_data_in 01101 then 01010; vld0 with prod=10'd130, err=0.
- Signed ops on requester 1: a1=5'b11101 (-3), b1=5'b01010 -> prod=10'h3E2 (-30). Then a1=5'b11101, b1=5'b11010 -> prod=10'd18.
- Contention: req0 and req1 high together in IDLE.
  - With macro: grants alternate 0,1,0 across three back-to-back ops.
  - Without macro: req1 starves while req0 stays high.
  - Never two acks or vlds in the same cycle.
- Zero operand: a0=0, b0=5'b01010 -> prod=0. The m_done pulse presented in CAP_HI is ignored.
- Timeout: model never asserts done -> after TIMEOUT WAIT cycles, vld0=1, err=1, prod=0, arbiter back in IDLE and accepts the next request normally.
- Reset mid-op: assert rst during WAIT -> no vld0; all outputs 0 next cycle; a fresh req1 after reset completes correctly.
